// File: rtl/mem_access_pkg.sv
// ---------------------------------------------------------------------------
// Module  : mem_access_pkg
// Brief   : Shared types and helpers for the Avalon-MM load/store master.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package mem_access_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [3:0] byteenable_f(input size_t size, input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << addr_lo;
            SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic misaligned_f(input size_t size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = |addr_lo;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ---------------------------------------------------------------------------
// Module  : mem_lane_align
// Brief   : Store-data lane replication and load-data lane select/extend.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mem_lane_align
    import mem_access_pkg::*;
(
    input  size_t       i_st_size,
    input  logic [31:0] i_st_wdata,
    output logic [31:0] o_st_wdata,
    input  size_t       i_ld_size,
    input  logic [1:0]  i_ld_addr_lo,
    input  logic        i_ld_signed,
    input  logic [31:0] i_ld_rdata,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_st_wdata = i_st_wdata;
        case (i_st_size)
            SZ_BYTE: o_st_wdata = {4{i_st_wdata[7:0]}};
            SZ_HALF: o_st_wdata = {2{i_st_wdata[15:0]}};
            default: o_st_wdata = i_st_wdata;
        endcase
    end

    always_comb begin
        w_byte = i_ld_rdata[7:0];
        case (i_ld_addr_lo)
            2'd0: w_byte = i_ld_rdata[7:0];
            2'd1: w_byte = i_ld_rdata[15:8];
            2'd2: w_byte = i_ld_rdata[23:16];
            2'd3: w_byte = i_ld_rdata[31:24];
            default: w_byte = i_ld_rdata[7:0];
        endcase
        w_half = i_ld_addr_lo[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];
    end

    always_comb begin
        o_ld_data = 32'd0;
        case (i_ld_size)
            SZ_BYTE: o_ld_data = {{24{i_ld_signed & w_byte[7]}}, w_byte};
            SZ_HALF: o_ld_data = {{16{i_ld_signed & w_half[15]}}, w_half};
            SZ_WORD: o_ld_data = i_ld_rdata;
            default: o_ld_data = 32'd0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/avalon_mem_master.sv
// ---------------------------------------------------------------------------
// Module  : avalon_mem_master
// Brief   : Avalon-MM initiator for the core's load/store stage, with
//           misalignment trapping and a bus-hang timeout.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module avalon_mem_master
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_signed,
    output logic        cpu_ready,
    output logic        cpu_done,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata
);

    localparam int              C_CW      = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [C_CW-1:0] C_TO_LAST = C_CW'(TIMEOUT_CYCLES - 1);
    localparam bit              C_TO_EN   = (TIMEOUT_CYCLES != 0);

    state_t          r_state;
    size_t           r_size;
    logic [1:0]      r_addr_lo;
    logic            r_signed;
    logic            r_we;
    logic [C_CW-1:0] r_cnt;
    logic [31:0]     r_address;
    logic            r_read;
    logic            r_write;
    logic [31:0]     r_writedata;
    logic [3:0]      r_byteenable;
    logic            r_done;
    logic [31:0]     r_rdata;
    logic            r_err;

    size_t       w_size;
    logic [31:0] w_st_wdata;
    logic [31:0] w_ld_data;

    assign w_size = size_t'(cpu_size);

    mem_lane_align u_align (
        .i_st_size    (w_size),
        .i_st_wdata   (cpu_wdata),
        .o_st_wdata   (w_st_wdata),
        .i_ld_size    (r_size),
        .i_ld_addr_lo (r_addr_lo),
        .i_ld_signed  (r_signed),
        .i_ld_rdata   (avm_readdata),
        .o_ld_data    (w_ld_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_size       <= SZ_BYTE;
            r_addr_lo    <= 2'd0;
            r_signed     <= 1'b0;
            r_we         <= 1'b0;
            r_cnt        <= '0;
            r_address    <= 32'd0;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_writedata  <= 32'd0;
            r_byteenable <= 4'd0;
            r_done       <= 1'b0;
            r_rdata      <= 32'd0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done  <= 1'b0;
                    r_rdata <= 32'd0;
                    r_err   <= 1'b0;
                    if (cpu_req) begin
                        r_size    <= w_size;
                        r_addr_lo <= cpu_addr[1:0];
                        r_signed  <= cpu_signed;
                        r_we      <= cpu_we;
                        // Illegal requests never reach the bus; answer straight away.
                        if (misaligned_f(w_size, cpu_addr[1:0])) begin
                            r_state <= RESP;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_state      <= BUS;
                            r_cnt        <= '0;
                            r_address    <= {cpu_addr[31:2], 2'b00};
                            r_byteenable <= byteenable_f(w_size, cpu_addr[1:0]);
                            r_writedata  <= w_st_wdata;
                            r_read       <= ~cpu_we;
                            r_write      <= cpu_we;
                        end
                    end
                end
                BUS: begin
                    if (!avm_waitrequest) begin
                        r_state <= RESP;
                        r_read  <= 1'b0;
                        r_write <= 1'b0;
                        r_done  <= 1'b1;
                        r_rdata <= r_we ? 32'd0 : w_ld_data;
                    end else if (C_TO_EN && (r_cnt == C_TO_LAST)) begin
                        r_state <= RESP;
                        r_read  <= 1'b0;
                        r_write <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                        r_rdata <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_rdata <= 32'd0;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cpu_ready      = (r_state == IDLE);
    assign cpu_done       = r_done;
    assign cpu_rdata      = r_rdata;
    assign cpu_err        = r_err;
    assign avm_address    = r_address;
    assign avm_read       = r_read;
    assign avm_write      = r_write;
    assign avm_writedata  = r_writedata;
    assign avm_byteenable = r_byteenable;

endmodule

`default_nettype wire
